vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be: H_TOTAL 1904 clocks/line; V_TOTAL 932 lines/frame; H_ACT_START 384; H_ACT 1440; V_ACT_START 31; V_ACT 900; LOCK_FRAMES 2 (consecutive good frames needed for lock).
REQ-002 clk  in  1  pixel clock; one clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 hsync_in  in  1  horizontal sync, active-low pulse.
REQ-005 vsync_in  in  1  vertical sync, active-high pulse.
REQ-006 pix_r_in/pix_g_in/pix_b_in  in  4 each  incoming pixel colour.
REQ-007 de  out  1  registered data-enable for active pixels.
REQ-008 curr_x  out  11  active column, 0..1439.
REQ-009 curr_y  out  10  active row, 0..899.
REQ-010 draw_r/draw_g/draw_b  out  4 each  registered pixel colour.
REQ-011 locked  out  1  timing lock indicator.
REQ-012 frame_start  out  1  one-cycle pulse at each detected frame start.
REQ-013 sync_err_cnt  out  8  saturating count of lock losses.

Function
REQ-014 Line start SHALL be the cycle in which hsync_in is sampled 0 while its previous sample was 1; that cycle is column hcnt=0, and subsequent cycles increment hcnt by 1.
REQ-015 hcnt (12 bits) SHALL saturate at 2*H_TOTAL (3808) when no line start occurs; reaching 3808 is a horizontal timeout.
REQ-016 At each line start: if vsync_in=1 and vsync was 0 at the previous line start, vcnt SHALL load 0 (frame start); otherwise vcnt increments, saturating at 2*V_TOTAL (1864) = vertical timeout.
REQ-017 A line SHALL be good iff hcnt at the terminating line start equals H_TOTAL-1 (1903); a frame good iff every line in it is good and vcnt at the next frame start equals V_TOTAL-1 (931).
REQ-018 Lock FSM states SHALL be UNLOCKED, CHECK, LOCKED; locked=1 only in LOCKED.
REQ-019 UNLOCKED -> CHECK on first frame start, good_frames cleared; the partial frame before it is never evaluated.
REQ-020 CHECK: at each frame start, good frame increments good_frames, bad frame clears it; reaching LOCK_FRAMES -> LOCKED.
REQ-021 LOCKED -> UNLOCKED on any bad line, bad frame, or either timeout; sync_err_cnt increments by 1 per transition, saturating at 255.
REQ-022 CHECK SHALL also return to UNLOCKED on a timeout, without incrementing sync_err_cnt.
REQ-023 de SHALL be 1 one cycle after a cycle with state LOCKED, H_ACT_START<=hcnt<=1823 and V_ACT_START<=vcnt<=930; curr_x=hcnt-384, curr_y=vcnt-31 in that same registered cycle.
REQ-024 curr_x, curr_y, draw_* SHALL hold last values when de=0; draw_* SHALL capture pix_*_in whenever de is loaded 1 (one-cycle latency, aligned with curr_x/curr_y).
REQ-025 frame_start SHALL pulse one cycle after each frame-start cycle, in every FSM state.
REQ-026 Simultaneous lock-loss and active-region condition SHALL give de=0 (loss wins).

Reset
REQ-027 While rst_n=0, immediately: de, curr_x, curr_y, draw_*, locked, frame_start, sync_err_cnt all 0; hcnt=0, vcnt=0, FSM=UNLOCKED, good_frames=0.
REQ-028 Stored previous hsync sample SHALL reset to 0 and previous vsync to 1, so a sync level held through reset release is not an edge.
REQ-029 Reset asserted mid-frame SHALL discard all timing; lock requires a fresh frame start plus LOCK_FRAMES good frames.

Verification
REQ-030 Reset, nominal 1904x932 timing (hsync low 152 clocks, vsync high lines 0-2): frame starts F1, F2, F3 -> locked=1 one cycle after F3; sync_err_cnt=0.
REQ-031 Locked; drive pix_r_in=0xA at hcnt=384,vcnt=31 -> next cycle de=1, curr_x=0, curr_y=0, draw_r=0xA; hcnt=1823,vcnt=930 -> curr_x=1439, curr_y=899; hcnt=1824 -> de=0 next cycle.
REQ-032 Locked; one line of 1903 clocks -> locked=0, de=0, sync_err_cnt 0->1; relock after 1 frame start plus 2 good frames.
REQ-033 Locked; hsync_in held 1 for 3808 clocks -> locked=0, sync_err_cnt+1, hcnt holds 3808 until next falling edge.
REQ-034 rst_n pulsed low mid-line while locked -> all outputs 0 in same cycle; hsync held low across release produces no line start.
REQ-035 Force 256 lock losses -> sync_err_cnt stays 255.

Source files
------------

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_sync_decoder                                           |
// | Description : Recovers pixel/line position from incoming HSYNC/VSYNC,    |
// |               qualifies the timing over consecutive frames and, once     |
// |               locked, emits a registered data-enable with the active     |
// |               column/row and the captured pixel colour.                  |
// |                                                                          |
// | Ports                                                                    |
// |   clk           in   1   pixel clock, all state on the rising edge       |
// |   rst_n         in   1   asynchronous active-low reset                   |
// |   hsync_in      in   1   horizontal sync, active-low pulse               |
// |   vsync_in      in   1   vertical sync, active-high pulse                |
// |   pix_*_in      in   4   incoming pixel colour (r/g/b)                   |
// |   de            out  1   registered data-enable for active pixels        |
// |   curr_x        out  11  active column                                   |
// |   curr_y        out  10  active row                                      |
// |   draw_*        out  4   registered pixel colour (r/g/b)                 |
// |   locked        out  1   timing lock indicator                           |
// |   frame_start   out  1   one-cycle pulse after each detected frame start |
// |   sync_err_cnt  out  8   saturating count of lock losses                 |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module vga_sync_decoder #(
  parameter int H_TOTAL     = 1904,
  parameter int V_TOTAL     = 932,
  parameter int H_ACT_START = 384,
  parameter int H_ACT       = 1440,
  parameter int V_ACT_START = 31,
  parameter int V_ACT       = 900,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [3:0]  pix_r_in,
  input  logic [3:0]  pix_g_in,
  input  logic [3:0]  pix_b_in,
  output logic        de,
  output logic [10:0] curr_x,
  output logic [9:0]  curr_y,
  output logic [3:0]  draw_r,
  output logic [3:0]  draw_g,
  output logic [3:0]  draw_b,
  output logic        locked,
  output logic        frame_start,
  output logic [7:0]  sync_err_cnt
);

  // Counter limits. Saturation at twice the nominal period doubles as the
  // timeout indication, so no separate watchdog counters are needed.
  localparam logic [11:0] c_H_SAT       = 12'(2 * H_TOTAL);
  localparam logic [11:0] c_H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] c_H_ACT_FIRST = 12'(H_ACT_START);
  localparam logic [11:0] c_H_ACT_LAST  = 12'(H_ACT_START + H_ACT - 1);
  localparam logic [10:0] c_V_SAT       = 11'(2 * V_TOTAL);
  localparam logic [10:0] c_V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] c_V_ACT_FIRST = 11'(V_ACT_START);
  localparam logic [10:0] c_V_ACT_LAST  = 11'(V_ACT_START + V_ACT - 1);
  localparam int          c_GF_W        = $clog2(LOCK_FRAMES + 1);
  localparam logic [c_GF_W-1:0] c_GF_LAST = c_GF_W'(LOCK_FRAMES - 1);
  localparam logic [7:0]  c_ERR_MAX     = 8'hFF;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_CHECK    = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_GF_W-1:0]   r_good;
  logic [c_GF_W-1:0]   w_good_nxt;
  logic                w_loss;

  logic                r_hsync_prev;
  logic                r_vsync_ls;    // vsync level seen at the previous line start
  logic [11:0]         r_hcnt;
  logic [10:0]         r_vcnt;
  logic                r_frame_ok;    // every line terminated so far in this frame was good

  logic                w_line_start;
  logic                w_frame_start;
  logic                w_line_good;
  logic                w_frame_good;
  logic                w_timeout;
  logic                w_active;
  logic                w_de_nxt;

  // Edge detection is done against the live input so the counter reload
  // happens on the same edge that samples the falling hsync.
  assign w_line_start  = ~hsync_in & r_hsync_prev;
  assign w_frame_start = w_line_start & vsync_in & ~r_vsync_ls;
  assign w_line_good   = (r_hcnt == c_H_LAST);
  // The line terminated by this frame start still belongs to the old frame.
  assign w_frame_good  = r_frame_ok & w_line_good & (r_vcnt == c_V_LAST);
  assign w_timeout     = (r_hcnt == c_H_SAT) | (r_vcnt == c_V_SAT);
  assign w_active      = (r_hcnt >= c_H_ACT_FIRST) && (r_hcnt <= c_H_ACT_LAST) &&
                         (r_vcnt >= c_V_ACT_FIRST) && (r_vcnt <= c_V_ACT_LAST);
  // A lock loss in the same cycle suppresses the data-enable.
  assign w_de_nxt      = (r_state == S_LOCKED) & ~w_loss & w_active;

  // Line / frame position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync_prev <= 1'b0;   // a low hsync held through release is not an edge
      r_vsync_ls   <= 1'b1;   // a high vsync held through release is not an edge
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_frame_ok   <= 1'b0;
    end else begin
      r_hsync_prev <= hsync_in;
      if (w_line_start) begin
        r_hcnt     <= '0;
        r_vsync_ls <= vsync_in;
        if (w_frame_start) begin
          r_vcnt     <= '0;
          r_frame_ok <= 1'b1;
        end else begin
          if (r_vcnt != c_V_SAT) begin
            r_vcnt <= r_vcnt + 11'd1;
          end
          r_frame_ok <= r_frame_ok & w_line_good;
        end
      end else if (r_hcnt != c_H_SAT) begin
        r_hcnt <= r_hcnt + 12'd1;
      end
    end
  end

  // Lock FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_UNLOCKED;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  // Lock FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_loss      = 1'b0;
    case (r_state)
      S_UNLOCKED: begin
        // The partial frame preceding the first frame start is never judged.
        if (w_frame_start) begin
          w_state_nxt = S_CHECK;
          w_good_nxt  = '0;
        end
      end
      S_CHECK: begin
        if (w_timeout) begin
          w_state_nxt = S_UNLOCKED;
          w_good_nxt  = '0;
        end else if (w_frame_start) begin
          if (!w_frame_good) begin
            w_good_nxt = '0;
          end else if (r_good == c_GF_LAST) begin
            w_state_nxt = S_LOCKED;
            w_good_nxt  = '0;
          end else begin
            w_good_nxt = r_good + 1'b1;
          end
        end
      end
      S_LOCKED: begin
        if (w_timeout || (w_line_start && !w_line_good) ||
            (w_frame_start && !w_frame_good)) begin
          w_state_nxt = S_UNLOCKED;
          w_good_nxt  = '0;
          w_loss      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_UNLOCKED;
        w_good_nxt  = '0;
      end
    endcase
  end

  assign locked = (r_state == S_LOCKED);

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de           <= 1'b0;
      curr_x       <= '0;
      curr_y       <= '0;
      draw_r       <= '0;
      draw_g       <= '0;
      draw_b       <= '0;
      frame_start  <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      frame_start <= w_frame_start;
      de          <= w_de_nxt;
      // Position and colour hold their last values outside the active area.
      if (w_de_nxt) begin
        curr_x <= 11'(r_hcnt - c_H_ACT_FIRST);
        curr_y <= 10'(r_vcnt - c_V_ACT_FIRST);
        draw_r <= pix_r_in;
        draw_g <= pix_g_in;
        draw_b <= pix_b_in;
      end
      if (w_loss && (sync_err_cnt != c_ERR_MAX)) begin
        sync_err_cnt <= sync_err_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vga_sync_decoder                                        |
// | Description : Self-checking bench for vga_sync_decoder. Uses a reduced   |
// |               timing (12 clocks/line, 4 lines/frame) so that hundreds of |
// |               lock/unlock cycles fit in a short run. Expected outputs    |
// |               come from a line/frame level model of the sync rules.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_vga_sync_decoder;

  localparam int TH    = 12;
  localparam int TV    = 4;
  localparam int THAS  = 3;
  localparam int THACT = 7;
  localparam int TVAS  = 1;
  localparam int TVACT = 2;
  localparam int TLF   = 2;
  localparam int HSW   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync_in;
  logic        vsync_in;
  logic [3:0]  pix_r_in, pix_g_in, pix_b_in;
  logic        de;
  logic [10:0] curr_x;
  logic [9:0]  curr_y;
  logic [3:0]  draw_r, draw_g, draw_b;
  logic        locked;
  logic        frame_start;
  logic [7:0]  sync_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_hs_prev;
  bit          m_vs_ls;
  int          m_h;          // clocks since the last line start (saturating)
  int          m_lens[$];    // hcnt of each line terminated since the last frame start
  bit          m_locked;
  bit          m_checking;
  int          m_streak;
  int          m_err;
  bit          e_de;
  bit          e_fs;
  logic [10:0] e_x;
  logic [9:0]  e_y;
  logic [3:0]  e_r, e_g, e_b;

  vga_sync_decoder #(
    .H_TOTAL     (TH),
    .V_TOTAL     (TV),
    .H_ACT_START (THAS),
    .H_ACT       (THACT),
    .V_ACT_START (TVAS),
    .V_ACT       (TVACT),
    .LOCK_FRAMES (TLF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .pix_r_in     (pix_r_in),
    .pix_g_in     (pix_g_in),
    .pix_b_in     (pix_b_in),
    .de           (de),
    .curr_x       (curr_x),
    .curr_y       (curr_y),
    .draw_r       (draw_r),
    .draw_g       (draw_g),
    .draw_b       (draw_b),
    .locked       (locked),
    .frame_start  (frame_start),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hs_prev  = 1'b0;
    m_vs_ls    = 1'b1;
    m_h        = 0;
    m_lens.delete();
    m_locked   = 1'b0;
    m_checking = 1'b0;
    m_streak   = 0;
    m_err      = 0;
    e_de = 1'b0; e_fs = 1'b0;
    e_x = '0; e_y = '0; e_r = '0; e_g = '0; e_b = '0;
  endtask

  // One pixel clock: drive inputs, predict, clock, compare every output.
  task automatic step_pix(input bit hs, input bit vs, input logic [3:0] r,
                          input logic [3:0] g, input logic [3:0] b);
    bit ls, fs, timeout, line_ok, frame_ok, was_locked, loss;
    int v;
    hsync_in = hs; vsync_in = vs;
    pix_r_in = r;  pix_g_in = g;  pix_b_in = b;

    v        = m_lens.size();
    ls       = !hs && m_hs_prev;
    fs       = ls && vs && !m_vs_ls;
    timeout  = (m_h == 2 * TH) || (v == 2 * TV);
    line_ok  = (m_h == TH - 1);
    frame_ok = line_ok && (v == TV - 1);
    foreach (m_lens[i]) if (m_lens[i] != TH - 1) frame_ok = 1'b0;

    was_locked = m_locked;
    loss       = 1'b0;
    if (m_locked) begin
      if (timeout || (ls && !line_ok) || (fs && !frame_ok)) begin
        m_locked = 1'b0;
        loss     = 1'b1;
        if (m_err < 255) m_err++;
      end
    end else if (m_checking) begin
      if (timeout) begin
        m_checking = 1'b0;
      end else if (fs) begin
        m_streak = frame_ok ? m_streak + 1 : 0;
        if (m_streak >= TLF) begin
          m_checking = 1'b0;
          m_locked   = 1'b1;
        end
      end
    end else if (fs) begin
      m_checking = 1'b1;
      m_streak   = 0;
    end

    e_fs = fs;
    e_de = was_locked && !loss && (m_h >= THAS) && (m_h < THAS + THACT) &&
           (v >= TVAS) && (v < TVAS + TVACT);
    if (e_de) begin
      e_x = 11'(m_h - THAS);
      e_y = 10'(v - TVAS);
      e_r = r; e_g = g; e_b = b;
    end

    if (ls) begin
      if (fs) m_lens.delete();
      else if (m_lens.size() < 2 * TV) m_lens.push_back(m_h);
      m_h     = 0;
      m_vs_ls = vs;
    end else if (m_h < 2 * TH) begin
      m_h++;
    end
    m_hs_prev = hs;

    @(posedge clk); #1;
    chk("cycle_outputs",
        {de, locked, frame_start, sync_err_cnt, curr_x, curr_y, draw_r, draw_g, draw_b},
        {e_de, m_locked, e_fs, 8'(m_err), e_x, e_y, e_r, e_g, e_b});
  endtask

  task automatic step(input bit hs, input bit vs);
    step_pix(hs, vs, 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic line(input int len, input bit vs);
    for (int k = 0; k < len; k++) step(k >= HSW, vs);
  endtask

  task automatic frame();
    for (int r = 0; r < TV; r++) line(TH, r == 0);
  endtask

  initial begin
    rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b0;
    pix_r_in = '0; pix_g_in = '0; pix_b_in = '0;
    model_reset();
    #12;
    chk("reset_de", de, 0);
    chk("reset_locked", locked, 0);
    chk("reset_err", sync_err_cnt, 0);
    chk("reset_pos", {curr_x, curr_y}, 0);
    @(posedge clk); #3 rst_n = 1'b1;

    // Partial frame, then F1, F2; lock one cycle after F3
    line(TH, 1'b0); line(TH, 1'b0);
    frame(); frame();
    chk("locked_before_f3", locked, 0);
    for (int r = 0; r < TV; r++) begin
      for (int k = 0; k < TH; k++) begin
        if (r == TVAS && k == THAS + 1) begin
          step_pix(k >= HSW, r == 0, 4'hA, 4'h3, 4'h5);
          chk("first_px_de", de, 1);
          chk("first_px_xy", {curr_x, curr_y}, 0);
          chk("first_px_r", draw_r, 4'hA);
        end else if (r == TVAS + TVACT - 1 && k == THAS + THACT) begin
          step(k >= HSW, r == 0);
          chk("last_px_x", curr_x, THACT - 1);
          chk("last_px_y", curr_y, TVACT - 1);
        end else if (r == TVAS + TVACT - 1 && k == THAS + THACT + 1) begin
          step(k >= HSW, r == 0);
          chk("past_last_px_de", de, 0);
        end else begin
          step(k >= HSW, r == 0);
          if (r == 0 && k == 0) begin
            chk("f3_locked", locked, 1);
            chk("f3_frame_start", frame_start, 1);
            chk("f3_err", sync_err_cnt, 0);
          end
        end
      end
    end

    // Short line while locked
    line(TH, 1'b1); line(TH - 1, 1'b0);
    step(1'b0, 1'b0);
    chk("short_line_locked", locked, 0);
    chk("short_line_de", de, 0);
    chk("short_line_err", sync_err_cnt, 1);
    for (int k = 1; k < TH; k++) step(k >= HSW, 1'b0);
    line(TH, 1'b0);
    frame(); frame(); frame();
    chk("relock_after_short", locked, 1);

    // Horizontal timeout while locked
    line(TH, 1'b1);
    line(2 * TH + 5, 1'b0);
    chk("htimeout_locked", locked, 0);
    chk("htimeout_err", sync_err_cnt, 2);
    chk("htimeout_hcnt_hold", dut.r_hcnt, 2 * TH);
    line(TH, 1'b0);
    frame(); frame(); frame();
    chk("relock_after_timeout", locked, 1);

    // Randomised line lengths and missing vsyncs
    for (int f = 0; f < 40; f++) begin
      bit skip_vs;
      skip_vs = ($urandom_range(0, 9) == 0);
      for (int r = 0; r < TV; r++) begin
        int len, p;
        len = TH;
        p = int'($urandom_range(0, 19));
        if (p == 0) len = int'($urandom_range(TH - 3, TH + 3));
        else if (p == 1) len = 2 * TH + 3;
        line(len, (r == 0) && !skip_vs);
      end
    end
    frame(); frame(); frame();
    chk("relock_after_random", locked, 1);

    // Reset mid-line, with sync levels held across the release
    line(TH, 1'b1);
    for (int k = 0; k < 5; k++) step(k >= HSW, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_de", de, 0);
    chk("midreset_locked", locked, 0);
    chk("midreset_err", sync_err_cnt, 0);
    chk("midreset_outputs", {frame_start, curr_x, curr_y, draw_r, draw_g, draw_b}, 0);
    model_reset();
    hsync_in = 1'b0; vsync_in = 1'b1;
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
    chk("no_edge_after_release", dut.r_hcnt, 4);
    for (int k = 0; k < TH - 6; k++) step(1'b1, 1'b1);
    line(TH, 1'b1);
    line(TH, 1'b0);
    frame(); frame(); frame();
    chk("relock_after_reset", locked, 1);
    chk("err_after_reset", sync_err_cnt, 0);

    // Error counter saturation
    for (int it = 0; it < 258; it++) begin
      frame(); frame();
      line(TH - 1, 1'b1);
      for (int r = 1; r < TV; r++) line(TH, 1'b0);
      if (it == 254) chk("err_reaches_255", sync_err_cnt, 255);
    end
    chk("err_saturated", sync_err_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
